urna_teclado: RTL and testbench

Keypad front end for the voting machine: synchronises and debounces the raw push-buttons, encodes key presses, and buffers a two-digit candidate entry with correct/confirm editing. On confirm it replays the two digits to the vote-counting stage as two `valid` strobes on `digit`. It also delivers a debounced `finish` level. It sits directly upstream of the vote counter and drives its `digit`, `valid` and `finish` inputs.

---
 rtl/urna_pkg.sv | 25 ++
 rtl/urna_debounce.sv | 44 ++++
 rtl/urna_teclado.sv | 164 ++++++++++++++++
 tb/tb_urna_teclado.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/urna_pkg.sv
// Shared constants, FSM state type and counter sizing for the voting keypad front end.
package urna_pkg;

  localparam int NUM_KEYS            = 12;
  localparam int KEY_CONFIRMA        = 10;
  localparam int KEY_CORRIGE         = 11;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int GAP_CYCLES_DEF      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ONE,
    ST_TWO,
    ST_SEND1,
    ST_GAP,
    ST_SEND2
  } state_e;

  function automatic int db_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int DB_CNT_W_DEF = db_cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/urna_debounce.sv
// Two-flop synchroniser followed by a down-counting debouncer for one raw line.
module urna_debounce
  import urna_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o
);

  localparam int            CW     = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // Counter reloads whenever input agrees with output, so any bounce restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= RELOAD;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        cnt_q <= RELOAD;
      end else if (cnt_q == '0) begin
        db_q  <= sync2_q;
        cnt_q <= RELOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/urna_teclado.sv
// Keypad front end: debounced keys, press encoder, two-digit entry buffer and replay FSM.
//   state | meaning
//   IDLE  | no digits buffered
//   ONE   | first digit held in d1
//   TWO   | both digits held, waiting for CONFIRMA/CORRIGE
//   SEND1 | strobe d1
//   GAP   | hold d1 for GAP_CYCLES idle cycles
//   SEND2 | strobe d2, then back to IDLE
module urna_teclado
  import urna_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int GAP_CYCLES      = GAP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  input  logic                finish_raw_i,
  output logic [3:0]          digit_o,
  output logic                valid_o,
  output logic                finish_o,
  output logic                busy_o,
  output logic [1:0]          entry_count_o
);

  localparam int            GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    IDX_CONF   = 4'(KEY_CONFIRMA);
  localparam logic [3:0]    IDX_CORR   = 4'(KEY_CORRIGE);

  logic [NUM_KEYS:0]   raw_all;
  logic [NUM_KEYS:0]   db_all;
  logic [NUM_KEYS-1:0] keys_db;
  logic                fin_db;

  assign raw_all = {finish_raw_i, key_raw_i};

  for (genvar i = 0; i <= NUM_KEYS; i++) begin : g_db
    urna_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw_all[i]),
      .db_o  (db_all[i])
    );
  end

  assign keys_db = db_all[NUM_KEYS-1:0];
  assign fin_db  = db_all[NUM_KEYS];

  logic [NUM_KEYS-1:0] keys_prev_q;
  logic                evt_q;
  logic [3:0]          evt_key_q;
  logic [3:0]          key_idx_d;
  logic                press_d;

  always_comb begin
    key_idx_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys_db[i]) key_idx_d = 4'(i);
    end
    // Only a clean single key rising out of all-released counts; chords never do.
    press_d = (keys_prev_q == '0) && $onehot(keys_db);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_prev_q <= '0;
      evt_q       <= 1'b0;
      evt_key_q   <= '0;
    end else begin
      keys_prev_q <= keys_db;
      evt_q       <= press_d;
      evt_key_q   <= key_idx_d;
    end
  end

  state_e        state_q;
  logic [3:0]    d1_q, d2_q;
  logic [3:0]    digit_q;
  logic          valid_q, finish_q, busy_q;
  logic [1:0]    entry_q;
  logic [GW-1:0] gap_q;
  logic          digit_ev, conf_ev, corr_ev, fin_rise;

  assign digit_ev = evt_q && (evt_key_q <= 4'd9) && !finish_q;
  assign conf_ev  = evt_q && (evt_key_q == IDX_CONF);
  assign corr_ev  = evt_q && (evt_key_q == IDX_CORR);
  assign fin_rise = fin_db && !finish_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      d1_q     <= '0;
      d2_q     <= '0;
      digit_q  <= '0;
      valid_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      entry_q  <= '0;
      gap_q    <= '0;
    end else begin
      // Finish is frozen while the replay is in flight and catches up on leaving SEND2.
      if (state_q != ST_SEND1 && state_q != ST_GAP) finish_q <= fin_db;
      case (state_q)
        ST_IDLE: begin
          if (digit_ev) begin
            d1_q    <= evt_key_q;
            entry_q <= 2'd1;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (fin_rise || corr_ev) begin
            entry_q <= 2'd0;
            state_q <= ST_IDLE;
          end else if (digit_ev) begin
            d2_q    <= evt_key_q;
            entry_q <= 2'd2;
            state_q <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (fin_rise || corr_ev) begin
            entry_q <= 2'd0;
            state_q <= ST_IDLE;
          end else if (conf_ev) begin
            digit_q <= d1_q;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          valid_q <= 1'b0;
          gap_q   <= GAP_RELOAD;
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            digit_q <= d2_q;
            valid_q <= 1'b1;
            state_q <= ST_SEND2;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        ST_SEND2: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          entry_q <= 2'd0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign digit_o       = digit_q;
  assign valid_o       = valid_q;
  assign finish_o      = finish_q;
  assign busy_o        = busy_q;
  assign entry_count_o = entry_q;

endmodule

// File: tb/tb_urna_teclado.sv
// Directed bench for urna_teclado with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
module tb_urna_teclado;

  logic        clk;
  logic        rst;
  logic [11:0] key_raw_i;
  logic        finish_raw_i;
  logic [3:0]  digit_o;
  logic        valid_o;
  logic        finish_o;
  logic        busy_o;
  logic [1:0]  entry_count_o;

  int tests;
  int failed;

  urna_teclado #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_raw_i     (key_raw_i),
    .finish_raw_i  (finish_raw_i),
    .digit_o       (digit_o),
    .valid_o       (valid_o),
    .finish_o      (finish_o),
    .busy_o        (busy_o),
    .entry_count_o (entry_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  int sq_dig[$];
  int sq_cyc[$];
  int busy_cnt;
  int dbl_valid;
  int fin_rise_cyc;
  bit prev_valid;
  bit prev_fin;

  always @(posedge clk) cyc++;

  // Strobe log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_fin   = 1'b0;
    end else begin
      if (valid_o) begin
        sq_dig.push_back(int'(digit_o));
        sq_cyc.push_back(cyc);
        if (prev_valid) dbl_valid++;
      end
      if (busy_o) busy_cnt++;
      if (finish_o && !prev_fin) fin_rise_cyc = cyc;
      prev_valid = valid_o;
      prev_fin   = finish_o;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    sq_dig.delete();
    sq_cyc.delete();
    busy_cnt     = 0;
    fin_rise_cyc = -1;
  endtask

  function automatic int qdig(input int i);
    return (i < sq_dig.size()) ? sq_dig[i] : -1;
  endfunction

  function automatic int qcyc(input int i);
    return (i < sq_cyc.size()) ? sq_cyc[i] : -1;
  endfunction

  task automatic press(input int k);
    key_raw_i = 12'(1) << k;
    repeat (10) tick();
    key_raw_i = '0;
    repeat (12) tick();
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit ok;

  initial begin
    tests = 0;
    failed = 0;
    dbl_valid = 0;
    rst = 1'b1;
    key_raw_i = '0;
    finish_raw_i = 1'b0;
    clear_log();
    repeat (3) tick();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_digit", int'(digit_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_entry", int'(entry_count_o), 0);
    chk("rst_finish", int'(finish_o), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean 1, 3, CONFIRMA
    press(1);
    chk("s1_entry_after_1", int'(entry_count_o), 1);
    press(3);
    chk("s1_entry_after_3", int'(entry_count_o), 2);
    clear_log();
    press(10);
    chk("s1_strobe_count", sq_dig.size(), 2);
    chk("s1_digit0", qdig(0), 1);
    chk("s1_digit1", qdig(1), 3);
    chk("s1_spacing", qcyc(1) - qcyc(0), 3);
    chk("s1_busy_cycles", busy_cnt, 4);
    chk("s1_entry_end", int'(entry_count_o), 0);

    // Bouncing key 5
    key_raw_i = 12'h020; repeat (2) tick();
    key_raw_i = 12'h000; repeat (2) tick();
    key_raw_i = 12'h020; repeat (2) tick();
    key_raw_i = 12'h000; repeat (2) tick();
    key_raw_i = 12'h020; repeat (10) tick();
    key_raw_i = 12'h000; repeat (12) tick();
    chk("s2_entry_bounce", int'(entry_count_o), 1);
    press(11);
    chk("s2_entry_corrige", int'(entry_count_o), 0);

    // Chord 2+7 then 4
    key_raw_i = 12'h084; repeat (10) tick();
    key_raw_i = 12'h000; repeat (12) tick();
    chk("s3_entry_chord", int'(entry_count_o), 0);
    press(4);
    chk("s3_entry_after_4", int'(entry_count_o), 1);
    clear_log();
    press(5);
    press(10);
    chk("s3_strobe_count", sq_dig.size(), 2);
    chk("s3_digit0", qdig(0), 4);
    chk("s3_digit1", qdig(1), 5);

    // 9, 8, CORRIGE, 0, 1, CONFIRMA
    clear_log();
    press(9);
    press(8);
    press(11);
    chk("s4_entry_corrige", int'(entry_count_o), 0);
    press(0);
    press(1);
    press(10);
    chk("s4_strobe_count", sq_dig.size(), 2);
    chk("s4_digit0", qdig(0), 0);
    chk("s4_digit1", qdig(1), 1);

    // Key 6 and finish arriving while the replay is in flight
    press(2);
    press(3);
    clear_log();
    key_raw_i = 12'h400;
    repeat (4) tick();
    key_raw_i = 12'h440;
    finish_raw_i = 1'b1;
    repeat (6) tick();
    key_raw_i = '0;
    repeat (15) tick();
    chk("s5_strobe_count", sq_dig.size(), 2);
    chk("s5_digit0", qdig(0), 2);
    chk("s5_digit1", qdig(1), 3);
    chk("s5_finish_after_send2", fin_rise_cyc, qcyc(1) + 1);
    chk("s5_finish_level", int'(finish_o), 1);
    chk("s5_entry_after_send", int'(entry_count_o), 0);
    press(7);
    chk("s5_digit_ignored", int'(entry_count_o), 0);
    chk("s5_no_new_strobe", sq_dig.size(), 2);
    finish_raw_i = 1'b0;
    repeat (14) tick();
    chk("s5_finish_low", int'(finish_o), 0);

    // Reset in the cycle after SEND1
    press(4);
    press(2);
    chk("s6_entry_before", int'(entry_count_o), 2);
    clear_log();
    key_raw_i = 12'h400;
    wait_valid(20, ok);
    chk("s6_strobe_seen", int'(ok), 1);
    chk("s6_first_digit", int'(digit_o), 4);
    tick();
    rst = 1'b1;
    key_raw_i = '0;
    #1;
    chk("s6_rst_valid", int'(valid_o), 0);
    chk("s6_rst_digit", int'(digit_o), 0);
    chk("s6_rst_busy", int'(busy_o), 0);
    chk("s6_rst_entry", int'(entry_count_o), 0);
    chk("s6_rst_finish", int'(finish_o), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("s6_single_strobe", sq_dig.size(), 1);
    chk("s6_valid_idle", int'(valid_o), 0);

    chk("valid_never_double", dbl_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
